chorus_fx_ctrl: RTL
===================

Name: chorus_fx_ctrl

Overview:
Controller that sequences the chorus effect datapath from the front-panel chorus switch.
- Synchronises and debounces the raw switch.
- Captures switch edges for the Nios II over an Avalon-MM slave (registered read, one cycle latency).
- Drives a click-free wet-gain ramp into the chorus mixer, stepping once per audio sample.
- Firmware can override the switch and set the target wet gain.

Parameters:
DB_COUNT, 50000, clk cycles the synchronised switch must hold a new level before the debounced level changes (1 ms at 50 MHz).
RAMP_STEP, 1, wet_gain increment/decrement per sample_tick.
TARGET_RESET, 8'h80, reset value of the TARGET register.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon register select
write  in  1  Avalon write strobe
writedata  in  8  Avalon write data
readdata  out  8  Avalon read data, registered
switch_in  in  1  raw asynchronous chorus switch
sample_tick  in  1  one-clk pulse per audio sample from the codec interface
wet_gain  out  8  wet-path gain to the chorus mixer, unsigned
fx_active  out  1  chorus datapath enable
irq  out  1  level interrupt to the CPU

Behaviour:
Reset and clocking:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- All state is flopped with async reset.
- Reset values: readdata=0, wet_gain=0, fx_active=0, irq=0, FSM=OFF, CONTROL=0, EDGE=0, TARGET=TARGET_RESET.
- Synchronisers reset to 0. Debounced level resets to 0 and its counter to 0.
- Reset mid-ramp aborts immediately to these values.

Switch input path:
- switch_in passes through a 2-FF synchroniser.
- Debounce counter clears whenever the synchronised level equals the debounced level. Otherwise it increments.
- When the counter reaches DB_COUNT-1, the debounced level takes the synchronised level and the counter clears.
- Net latency is DB_COUNT+2 clk from a stable switch change to the debounced change.

Register map (readdata <= mux(address) every clk, no read strobe, one-cycle latency):
- addr0 STATUS (RO): bit0 debounced switch, bit1 fx_active, bit2 ramping (state RAMP_UP or RAMP_DOWN), bits7:3 = 0.
- addr1 CONTROL (RW): bit0 ovr_en, bit1 ovr_val, bit2 irq_en, bits7:3 read 0.
- addr2 EDGE (W1C): bit0 rise captured, bit1 fall captured.
  - A capture event sets its bit.
  - Writing 1 clears it. If set and clear coincide on the same clk, set wins.
- addr3 TARGET (RW): target wet gain.
- irq = irq_en & (EDGE != 0), registered.

Enable request:
- req = ovr_en ? ovr_val : debounced level.

FSM (wet_gain changes only on cycles where sample_tick=1):
- OFF: wet_gain=0. If req=1 and TARGET>0, go to RAMP_UP.
- RAMP_UP: on each tick, wet_gain = min(wet_gain+RAMP_STEP, TARGET). On reaching TARGET, go to ON. If req=0, go to RAMP_DOWN immediately from the current gain, with no jump.
- ON: if req=0, go to RAMP_DOWN. Otherwise, on each tick, step wet_gain toward TARGET (up or down, saturating at TARGET).
- RAMP_DOWN: on each tick, wet_gain = max(wet_gain-RAMP_STEP, 0), computed without underflow. On reaching 0, go to OFF. If req=1, go to RAMP_UP.
- If TARGET < wet_gain during RAMP_UP, clamp wet_gain to TARGET on the next tick.
- TARGET=0 with req=1 in OFF: remain in OFF.

Outputs:
- fx_active = 1 in all states except OFF, registered with the state.

Edge capture:
- Edges are taken from the debounced level, not from req.

Test Plan:
- Reset check: assert reset_n=0 mid-RAMP_UP → readdata, wet_gain, fx_active and irq are 0 at once; TARGET reads 8'h80.
- Debounce: bench uses DB_COUNT=8. switch_in glitches high for 5 clk → debounced stays 0 and EDGE=0. Held high → debounced=1 at clk 10 and EDGE bit0=1.
- Full ramp: TARGET=4, ovr_en=1, ovr_val=1, ticks every 4 clk → wet_gain goes 1,2,3,4 on successive ticks, then ON. ovr_val=0 → wet_gain goes 3,2,1,0, then OFF with fx_active=0.
- Reversal: req drops when wet_gain=2 during RAMP_UP → next tick gives 1, with no jump; STATUS bit2 stays 1.
- Interrupt and W1C: irq_en=1 with a rise → irq=1. Write 8'h01 to addr2 on the same clk as a new fall → EDGE reads 8'h02 and irq stays 1.
- Target change in ON: TARGET 4→2 → wet_gain reads 3 then 2 over two ticks, with fx_active held at 1.

Source files
------------

// File: rtl/chorus_fx_ctrl.sv
// chorus_fx_ctrl
// Sequences the chorus effect datapath from the front-panel chorus switch.
// The raw switch is synchronised and debounced. Its debounced edges are latched
// for the CPU. A click-free wet-gain ramp is driven into the chorus mixer and
// steps once per audio sample.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   address/write/    Avalon-MM slave: 2-bit register select, write strobe,
//   writedata/        8-bit write data, registered 8-bit read data
//   readdata          (one cycle latency, no read strobe)
//   switch_in         raw asynchronous chorus switch
//   sample_tick       one-clk pulse per audio sample
//   wet_gain          unsigned wet-path gain to the mixer
//   fx_active         chorus datapath enable (high in every state except OFF)
//   irq               level interrupt: irq_en & any captured edge
//
// Register map:
//   0 STATUS  RO  {5'b0, ramping, fx_active, debounced switch}
//   1 CONTROL RW  {5'b0, irq_en, ovr_val, ovr_en}
//   2 EDGE    W1C {6'b0, fall, rise}
//   3 TARGET  RW  target wet gain
module chorus_fx_ctrl #(
    parameter int         DB_COUNT     = 50000,
    parameter int         RAMP_STEP    = 1,
    parameter logic [7:0] TARGET_RESET = 8'h80
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] address,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic       switch_in,
    input  logic       sample_tick,
    output logic [7:0] wet_gain,
    output logic       fx_active,
    output logic       irq
);

    localparam int               CNT_W    = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [8:0]       STEP9    = 9'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN
    } state_t;

    logic             sync1_reg, sync2_reg;
    logic             db_level_reg;
    logic [CNT_W-1:0] db_cnt_reg;
    logic [2:0]       ctrl_reg;
    logic [1:0]       edge_reg;
    logic [7:0]       target_reg;
    logic             irq_reg;
    logic [7:0]       readdata_reg;
    state_t           state_reg;
    logic [7:0]       wet_gain_reg;
    logic             fx_active_reg;

    // ---------------------------------------------------------------
    // Switch synchroniser and debounce
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            db_level_reg <= 1'b0;
            db_cnt_reg   <= '0;
        end else begin
            sync1_reg <= switch_in;
            sync2_reg <= sync1_reg;
            if (sync2_reg == db_level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == CNT_LAST) begin
                db_level_reg <= sync2_reg;
                db_cnt_reg   <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    // The debounced level flips on exactly the cycles where the counter
    // expires, so the edge events can be derived without an extra delay flop.
    logic db_update, db_rise, db_fall;
    assign db_update = (sync2_reg != db_level_reg) && (db_cnt_reg == CNT_LAST);
    assign db_rise   = db_update &  sync2_reg;
    assign db_fall   = db_update & ~sync2_reg;

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    logic wr_ctrl, wr_edge, wr_target;
    assign wr_ctrl   = write && (address == 2'd1);
    assign wr_edge   = write && (address == 2'd2);
    assign wr_target = write && (address == 2'd3);

    logic       ramping;
    logic [1:0] edge_next;
    assign ramping = (state_reg == ST_RAMP_UP) || (state_reg == ST_RAMP_DOWN);

    // Capture has priority over the write-one-to-clear on the same bit.
    assign edge_next[0] = db_rise | (edge_reg[0] & ~(wr_edge & writedata[0]));
    assign edge_next[1] = db_fall | (edge_reg[1] & ~(wr_edge & writedata[1]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg     <= 3'd0;
            edge_reg     <= 2'd0;
            target_reg   <= TARGET_RESET;
            irq_reg      <= 1'b0;
            readdata_reg <= 8'd0;
        end else begin
            if (wr_ctrl)   ctrl_reg   <= writedata[2:0];
            if (wr_target) target_reg <= writedata;
            edge_reg <= edge_next;
            irq_reg  <= ctrl_reg[2] & (|edge_reg);
            case (address)
                2'd0:    readdata_reg <= {5'd0, ramping, fx_active_reg, db_level_reg};
                2'd1:    readdata_reg <= {5'd0, ctrl_reg};
                2'd2:    readdata_reg <= {6'd0, edge_reg};
                default: readdata_reg <= target_reg;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Wet-gain ramp
    // ---------------------------------------------------------------
    logic       req;
    logic [8:0] gain_up;
    logic [7:0] up_sat, down_zero, down_sat;

    assign req = ctrl_reg[0] ? ctrl_reg[1] : db_level_reg;

    // All arithmetic is done 9 bits wide so neither direction can wrap.
    // up_sat also clamps a gain that is already above the target.
    assign gain_up   = {1'b0, wet_gain_reg} + STEP9;
    assign up_sat    = (gain_up >= {1'b0, target_reg}) ? target_reg : gain_up[7:0];
    assign down_zero = ({1'b0, wet_gain_reg} > STEP9) ? (wet_gain_reg - STEP9[7:0]) : 8'd0;
    assign down_sat  = ({1'b0, wet_gain_reg} > ({1'b0, target_reg} + STEP9))
                       ? (wet_gain_reg - STEP9[7:0]) : target_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_OFF;
            wet_gain_reg  <= 8'd0;
            fx_active_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    wet_gain_reg <= 8'd0;
                    if (req && (target_reg != 8'd0)) begin
                        state_reg     <= ST_RAMP_UP;
                        fx_active_reg <= 1'b1;
                    end
                end
                ST_RAMP_UP: begin
                    if (!req) begin
                        // Reverse from the present gain; no step this cycle.
                        state_reg <= ST_RAMP_DOWN;
                    end else if (sample_tick) begin
                        wet_gain_reg <= up_sat;
                        if (up_sat == target_reg) state_reg <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (!req) begin
                        state_reg <= ST_RAMP_DOWN;
                    end else if (sample_tick) begin
                        if (wet_gain_reg < target_reg)      wet_gain_reg <= up_sat;
                        else if (wet_gain_reg > target_reg) wet_gain_reg <= down_sat;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (req) begin
                        state_reg <= ST_RAMP_UP;
                    end else if (sample_tick) begin
                        wet_gain_reg <= down_zero;
                        if (down_zero == 8'd0) begin
                            state_reg     <= ST_OFF;
                            fx_active_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg     <= ST_OFF;
                    wet_gain_reg  <= 8'd0;
                    fx_active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign readdata  = readdata_reg;
    assign wet_gain  = wet_gain_reg;
    assign fx_active = fx_active_reg;
    assign irq       = irq_reg;

endmodule
